// File: rtl/axi_tester_pkg.sv
// AXI test sequencer shared types: FSM state encoding,
// error-count width and a saturating error-count adder.
package axi_tester_pkg;

  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_DATA,
    S_WR_WAIT,
    S_RD_CMD,
    S_RD_DATA,
    S_RD_WAIT,
    S_DONE
  } state_t;

  // Adds 0..2 errors to the count, clamping at all ones.
  function automatic logic [ERR_W-1:0] sat_add(
    input logic [ERR_W-1:0] a,
    input logic [1:0]       n
  );
    logic [ERR_W:0] s;
    s = {1'b0, a} + {{(ERR_W-1){1'b0}}, n};
    return s[ERR_W] ? '1 : s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/axi_pattern_gen.sv
// Test pattern generator: data = seed + beat (mod 2^DATA_WIDTH).
// Ports: seed, beat index in, pattern word out (combinational).
module axi_pattern_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [7:0]            beat,
  output logic [DATA_WIDTH-1:0] data
);

  assign data = seed + DATA_WIDTH'(beat);

endmodule

// File: rtl/axi_test_sequencer.sv
// AXI write-then-readback test sequencer driving a command-level master.
// Ports: i_axi_clk/i_axi_rst (sync, active-low); i_start/i_base_addr/
// i_len/i_seed test setup; o_busy/o_done/o_pass/o_timeout/o_id_err/
// o_err_count/o_first_err_beat status; master command strobes and
// fields; AXI-stream style write (o_w_*) and read (i_r_*) beat channels.
module axi_test_sequencer
  import axi_tester_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TEST_ID        = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [7:0]              i_len,
  input  logic [DATA_WIDTH-1:0]   i_seed,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic                    o_id_err,
  output logic [ERR_W-1:0]        o_err_count,
  output logic [7:0]              o_first_err_beat,
  input  logic                    i_mst_ready,
  input  logic [ID_WIDTH-1:0]     i_mst_resp_id,
  output logic                    o_start_write_stb,
  output logic                    o_start_read_stb,
  output logic [ID_WIDTH-1:0]     o_id,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [7:0]              o_data_len,
  output logic                    o_en_strb,
  output logic [DATA_WIDTH-1:0]   o_w_tdata,
  output logic [DATA_WIDTH/8-1:0] o_w_tstrb,
  output logic                    o_w_tlast,
  output logic                    o_w_tvalid,
  input  logic                    i_w_tready,
  input  logic [DATA_WIDTH-1:0]   i_r_tdata,
  input  logic                    i_r_tlast,
  input  logic                    i_r_tvalid,
  output logic                    o_r_tready
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] TID =
    ID_WIDTH'(TEST_ID);

  state_t                  state;
  logic [WDW-1:0]          wdog;
  logic [7:0]              beat;
  logic [DATA_WIDTH-1:0]   seed_q;
  logic                    data_err_seen;

  logic [7:0]              wr_idx;
  logic [DATA_WIDTH-1:0]   wr_pat;
  logic [DATA_WIDTH-1:0]   rd_pat;
  logic                    wr_hs;
  logic                    rd_hs;
  logic                    data_bad;
  logic                    len_bad;
  logic [1:0]              n_err;
  logic                    id_bad;
  logic                    wd_hit;

  // Tie-offs: constant for the whole test.
  assign o_id      = TID;
  assign o_en_strb = 1'b0;

  // Write generator looks one beat ahead so the next word is
  // ready to register on acceptance; beat 0 is loaded from WR_CMD.
  assign wr_idx = (state == S_WR_CMD) ? 8'd0 : beat + 8'd1;

  axi_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wr_gen (
    .seed (seed_q),
    .beat (wr_idx),
    .data (wr_pat)
  );

  axi_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_gen (
    .seed (seed_q),
    .beat (beat),
    .data (rd_pat)
  );

  assign wr_hs    = o_w_tvalid & i_w_tready;
  assign rd_hs    = o_r_tready & i_r_tvalid;
  assign data_bad = (i_r_tdata != rd_pat);
  assign len_bad  = i_r_tlast ? (beat < o_data_len)
                              : (beat == o_data_len);
  assign n_err    = {1'b0, data_bad} + {1'b0, len_bad};
  assign id_bad   = (i_mst_resp_id != TID);
  assign wd_hit   = (state != S_IDLE) && (state != S_DONE) &&
                    (wdog == WD_LAST);

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      state             <= S_IDLE;
      wdog              <= '0;
      beat              <= '0;
      seed_q            <= '0;
      data_err_seen     <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
      o_timeout         <= 1'b0;
      o_id_err          <= 1'b0;
      o_err_count       <= '0;
      o_first_err_beat  <= '0;
      o_start_write_stb <= 1'b0;
      o_start_read_stb  <= 1'b0;
      o_addr            <= '0;
      o_data_len        <= '0;
      o_w_tdata         <= '0;
      o_w_tstrb         <= '0;
      o_w_tlast         <= 1'b0;
      o_w_tvalid        <= 1'b0;
      o_r_tready        <= 1'b0;
    end else begin
      o_start_write_stb <= 1'b0;
      o_start_read_stb  <= 1'b0;
      o_done            <= 1'b0;
      wdog              <= wdog + 1'b1;
      if (wd_hit) begin
        o_timeout  <= 1'b1;
        o_w_tvalid <= 1'b0;
        o_w_tlast  <= 1'b0;
        o_w_tstrb  <= '0;
        o_r_tready <= 1'b0;
        wdog       <= '0;
        state      <= S_DONE;
      end else begin
        unique case (state)
          S_IDLE: begin
            wdog <= '0;
            if (i_start) begin
              o_addr           <= i_base_addr;
              o_data_len       <= i_len;
              seed_q           <= i_seed;
              o_err_count      <= '0;
              o_first_err_beat <= '0;
              data_err_seen    <= 1'b0;
              o_id_err         <= 1'b0;
              o_timeout        <= 1'b0;
              o_pass           <= 1'b0;
              o_busy           <= 1'b1;
              state            <= S_WR_CMD;
            end
          end
          // Strobe is shown for one cycle before valid rises,
          // so the two never overlap.
          S_WR_CMD: begin
            if (o_start_write_stb) begin
              o_w_tvalid <= 1'b1;
              o_w_tstrb  <= '1;
              o_w_tdata  <= wr_pat;
              o_w_tlast  <= (o_data_len == 8'd0);
              beat       <= '0;
              wdog       <= '0;
              state      <= S_WR_DATA;
            end else if (i_mst_ready) begin
              o_start_write_stb <= 1'b1;
            end
          end
          S_WR_DATA: begin
            if (wr_hs) begin
              if (o_w_tlast) begin
                o_w_tvalid <= 1'b0;
                o_w_tlast  <= 1'b0;
                o_w_tstrb  <= '0;
                beat       <= '0;
                wdog       <= '0;
                state      <= S_WR_WAIT;
              end else begin
                beat      <= beat + 8'd1;
                o_w_tdata <= wr_pat;
                o_w_tlast <= (beat + 8'd1 == o_data_len);
              end
            end
          end
          S_WR_WAIT: begin
            if (i_mst_ready) begin
              o_id_err <= o_id_err | id_bad;
              wdog     <= '0;
              state    <= S_RD_CMD;
            end
          end
          S_RD_CMD: begin
            if (o_start_read_stb) begin
              o_r_tready <= 1'b1;
              beat       <= '0;
              wdog       <= '0;
              state      <= S_RD_DATA;
            end else if (i_mst_ready) begin
              o_start_read_stb <= 1'b1;
            end
          end
          S_RD_DATA: begin
            if (rd_hs) begin
              if (data_bad && !data_err_seen) begin
                o_first_err_beat <= beat;
                data_err_seen    <= 1'b1;
              end
              o_err_count <= sat_add(o_err_count, n_err);
              if (i_r_tlast) begin
                o_r_tready <= 1'b0;
                wdog       <= '0;
                state      <= S_RD_WAIT;
              end else if (beat != 8'hFF) begin
                beat <= beat + 8'd1;
              end
            end
          end
          S_RD_WAIT: begin
            if (i_mst_ready) begin
              o_id_err <= o_id_err | id_bad;
              wdog     <= '0;
              state    <= S_DONE;
            end
          end
          S_DONE: begin
            o_done <= 1'b1;
            o_pass <= (o_err_count == '0) & ~o_id_err &
                      ~o_timeout;
            o_busy <= 1'b0;
            wdog   <= '0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_test_sequencer.sv
// Directed bench for axi_test_sequencer with a loopback
// command-level master / memory slave model.
module tb_axi_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  len;
  logic [31:0] seed;
  logic        busy, done, pass, timeout, id_err;
  logic [15:0] err_count;
  logic [7:0]  first_err_beat;
  logic        mst_ready;
  logic [3:0]  resp_id;
  logic        wr_stb, rd_stb;
  logic [3:0]  id;
  logic [31:0] addr;
  logic [7:0]  data_len;
  logic        en_strb;
  logic [31:0] w_tdata;
  logic [3:0]  w_tstrb;
  logic        w_tlast, w_tvalid, w_tready;
  logic [31:0] r_tdata;
  logic        r_tlast, r_tvalid, r_tready;

  int checks = 0;
  int failures = 0;

  // model controls (written only by the stimulus block)
  int   corrupt_beat = -1;
  int   early_last   = -1;
  logic no_bresp     = 1'b0;
  int   cur_len      = 0;

  // model state
  logic [31:0] mem [0:255];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  wlast_cyc = 0;
  int  wcnt = 0;
  int  rcnt = 0;
  int  bwait = 0;
  logic wphase = 1'b0;

  always #5 clk = ~clk;

  axi_test_sequencer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4),
    .TEST_ID(0), .TIMEOUT_CYCLES(64)
  ) dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n),
    .i_start(start), .i_base_addr(base_addr),
    .i_len(len), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_timeout(timeout), .o_id_err(id_err),
    .o_err_count(err_count),
    .o_first_err_beat(first_err_beat),
    .i_mst_ready(mst_ready), .i_mst_resp_id(resp_id),
    .o_start_write_stb(wr_stb), .o_start_read_stb(rd_stb),
    .o_id(id), .o_addr(addr), .o_data_len(data_len),
    .o_en_strb(en_strb),
    .o_w_tdata(w_tdata), .o_w_tstrb(w_tstrb),
    .o_w_tlast(w_tlast), .o_w_tvalid(w_tvalid),
    .i_w_tready(w_tready),
    .i_r_tdata(r_tdata), .i_r_tlast(r_tlast),
    .i_r_tvalid(r_tvalid), .o_r_tready(r_tready)
  );

  function automatic logic [31:0] rd_word(input int k);
    return mem[k] ^ ((k == corrupt_beat) ? 32'd1 : 32'd0);
  endfunction

  function automatic logic last_at(input int k);
    return (k == early_last) || (k == cur_len);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!rst_n) begin
      mst_ready <= 1'b1;
      w_tready  <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
      bwait     <= 0;
      wcnt      <= 0;
      rcnt      <= 0;
      wphase    <= 1'b0;
    end else begin
      if (wr_stb) begin
        mst_ready <= 1'b0;
        wphase    <= 1'b1;
        wcnt      <= 0;
        w_tready  <= 1'b1;
      end else if (wphase) begin
        w_tready <= ~w_tready;
        if (w_tvalid && w_tready) begin
          mem[wcnt] <= w_tdata;
          wcnt      <= wcnt + 1;
          if (w_tlast) begin
            wphase    <= 1'b0;
            w_tready  <= 1'b0;
            bwait     <= 3;
            wlast_cyc <= cyc;
          end
        end
      end
      if (bwait != 0) begin
        bwait <= bwait - 1;
        if (bwait == 1 && !no_bresp) mst_ready <= 1'b1;
      end
      if (rd_stb) begin
        mst_ready <= 1'b0;
        rcnt      <= 1;
        r_tvalid  <= 1'b1;
        r_tdata   <= rd_word(0);
        r_tlast   <= last_at(0);
      end else if (r_tvalid && r_tready) begin
        if (r_tlast) begin
          r_tvalid  <= 1'b0;
          r_tlast   <= 1'b0;
          mst_ready <= 1'b1;
        end else begin
          r_tdata <= rd_word(rcnt);
          r_tlast <= last_at(rcnt);
          rcnt    <= rcnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_test(input logic [31:0] b,
                            input logic [7:0] l,
                            input logic [31:0] s);
    @(negedge clk);
    base_addr = b;
    len       = l;
    seed      = s;
    cur_len   = int'(l);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt > d0), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int n;
    int diff;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    seed = '0;
    resp_id = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_outs", 32'(|{done, pass, timeout, id_err,
      err_count, first_err_beat, wr_stb, rd_stb, addr,
      data_len, en_strb, w_tdata, w_tstrb, w_tlast,
      w_tvalid, r_tready}), 0);
    check("rst_id", 32'(id), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // loopback pass, len=3 seed=1000
    d0 = done_cnt;
    start_test(32'h0000_4000, 8'd3, 32'h1000);
    check("t1_busy", 32'(busy), 1);
    check("t1_addr", addr, 32'h4000);
    check("t1_len", 32'(data_len), 3);
    wait_done(d0, "t1_done");
    check("t1_ndone", 32'(done_cnt - d0), 1);
    check("t1_mem0", mem[0], 32'h1000);
    check("t1_mem1", mem[1], 32'h1001);
    check("t1_mem2", mem[2], 32'h1002);
    check("t1_mem3", mem[3], 32'h1003);
    check("t1_pass", 32'(pass), 1);
    check("t1_err", 32'(err_count), 0);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_to", 32'(timeout), 0);

    // corrupted read beat 2
    corrupt_beat = 2;
    d0 = done_cnt;
    start_test(32'h0000_4000, 8'd3, 32'h1000);
    wait_done(d0, "t2_done");
    check("t2_err", 32'(err_count), 1);
    check("t2_first", 32'(first_err_beat), 2);
    check("t2_pass", 32'(pass), 0);
    corrupt_beat = -1;

    // early rlast on beat 1
    early_last = 1;
    d0 = done_cnt;
    start_test(32'h0000_4000, 8'd3, 32'h1000);
    wait_done(d0, "t3_done");
    check("t3_err", 32'(err_count), 1);
    check("t3_pass", 32'(pass), 0);
    early_last = -1;

    // wrong response ID
    resp_id = 4'd5;
    d0 = done_cnt;
    start_test(32'h0000_0100, 8'd0, 32'h55);
    wait_done(d0, "t4_done");
    check("t4_iderr", 32'(id_err), 1);
    check("t4_err", 32'(err_count), 0);
    check("t4_pass", 32'(pass), 0);
    resp_id = 4'd0;

    // wrap seed, len=1, start re-pulsed during read data
    d0 = done_cnt;
    start_test(32'h0000_8000, 8'd1, 32'hFFFF_FFFF);
    n = 0;
    while (!r_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_rd_reached", 32'(r_tready), 1);
    base_addr = 32'hDEAD_0000;
    len = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, "t5_done");
    repeat (20) @(negedge clk);
    check("t5_ndone", 32'(done_cnt - d0), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_addr", addr, 32'h8000);
    check("t5_mem0", mem[0], 32'hFFFF_FFFF);
    check("t5_mem1", mem[1], 32'h0000_0000);
    check("t5_pass", 32'(pass), 1);

    // missing write response -> watchdog
    no_bresp = 1'b1;
    d0 = done_cnt;
    start_test(32'h0000_0200, 8'd2, 32'h77);
    wait_done(d0, "t6_done");
    diff = done_cyc - wlast_cyc;
    check("t6_timeout", 32'(timeout), 1);
    check("t6_pass", 32'(pass), 0);
    check("t6_latency", 32'(diff >= 64 && diff <= 66), 1);
    check("t6_wvalid", 32'(w_tvalid), 0);
    no_bresp = 1'b0;
    do_reset();

    // reset during write beat 1
    d0 = done_cnt;
    start_test(32'h0000_0300, 8'd3, 32'h2000);
    n = 0;
    while (!(w_tvalid && w_tdata == 32'h2001) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t7_beat1", w_tdata, 32'h2001);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_outs", 32'(|{busy, done, pass, timeout, id_err,
      err_count, first_err_beat, wr_stb, rd_stb, addr,
      data_len, en_strb, w_tdata, w_tstrb, w_tlast,
      w_tvalid, r_tready}), 0);
    check("t7_id", 32'(id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_nodone", 32'(done_cnt - d0), 0);
    d0 = done_cnt;
    start_test(32'h0000_0300, 8'd3, 32'h2000);
    wait_done(d0, "t7_done");
    check("t7_pass", 32'(pass), 1);
    check("t7_mem3", mem[3], 32'h2003);
    check("t7_err", 32'(err_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
